module_periferico_timer: RTL

// - Memory-mapped countdown timer. It is the responder on the data bus at the timer word 0x2010.
// - Bus side: the bus conductor's we_timer_o drives we_i, the CPU store data drives di_i, and do_o returns to the conductor's do_timer_i.
// - Counts a programmed number of ticks, each tick PRESCALE clocks long, then raises a sticky done flag and a one-cycle irq_o.

---
 rtl/module_periferico_timer_if.sv | 15 +
 rtl/module_periferico_timer.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/module_periferico_timer_if.sv
// Bus bundle between the bus conductor and the countdown timer at word 0x2010.
// The conductor's we_timer_o drives we_i, the CPU store data drives di_i, and
// do_o returns to the conductor's do_timer_i. irq_o rides along with the bus.
// Handshake: a store is a single cycle with we_i=1, and di_i is valid in that
// cycle. There is no ready or backpressure, and every store is accepted on that
// edge. do_o is always valid, and reading it has no side effects.
interface module_periferico_timer_if;
   logic        we_i;
   logic [31:0] di_i;
   logic [31:0] do_o;
   logic        irq_o;

   modport master (output we_i, output di_i, input do_o, input irq_o);
   modport slave  (input we_i, input di_i, output do_o, output irq_o);
endinterface

// File: rtl/module_periferico_timer.sv
// Memory-mapped countdown timer.
// The timer counts LOAD ticks of PRESCALE clocks each. It then sets a sticky
// done flag and pulses irq_o for one cycle.
// di_i layout: [31] EN, [30] CLR_DONE, [29:0] LOAD.
// do_o layout: {done, running, count}.
// Optional feature macro TIMER_AUTORELOAD_EN: on expiry, reload the period and
// keep counting instead of stopping.
// The FSM state is exposed on state_dbg_o (0 IDLE, 1 COUNT, 2 EXPIRED).
module module_periferico_timer #(
   parameter int unsigned PRESCALE = 100000,
   parameter int unsigned CNT_W    = 30
) (
   input  logic                            clk_i,
   input  logic                            rst_n_i,
   module_periferico_timer_if.slave        bus,
   output logic [1:0]                      state_dbg_o
);

   // The prescaler needs at least one bit. With PRESCALE=1 it stays at 0 and
   // every clock is a tick.
   localparam int unsigned     PS_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COUNT   = 2'd1,
      ST_EXPIRED = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [PS_W-1:0]   prescaler_q, prescaler_d;
   logic              done_q, done_d;
   logic              irq_q, irq_d;
`ifdef TIMER_AUTORELOAD_EN
   // The reload value is only consumed when auto-reload is built in.
   logic [CNT_W-1:0]  period_q, period_d;
`endif

   logic              wr_en;
   logic              wr_clr;
   logic [CNT_W-1:0]  wr_load;
   logic              tick;
   logic              expire;
   logic              running;

   assign wr_en   = bus.di_i[31];
   assign wr_clr  = bus.di_i[30];
   assign wr_load = bus.di_i[CNT_W-1:0];

   // A tick completes on the last prescaler clock while counting.
   // Expiry is the tick that would take count from 1 to 0.
   assign tick   = (state_q == ST_COUNT) && (prescaler_q == PS_MAX);
   assign expire = tick && (count_q <= CNT_W'(1));

   // State register: every flop clears asynchronously, which also drops a pending irq.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= ST_IDLE;
         count_q     <= '0;
         prescaler_q <= '0;
         done_q      <= 1'b0;
         irq_q       <= 1'b0;
`ifdef TIMER_AUTORELOAD_EN
         period_q    <= '0;
`endif
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         prescaler_q <= prescaler_d;
         done_q      <= done_d;
         irq_q       <= irq_d;
`ifdef TIMER_AUTORELOAD_EN
         period_q    <= period_d;
`endif
      end
   end

   // Next-state decode: a write always wins over an expiry on the same edge.
   always_comb begin
      state_d = state_q;
      if (bus.we_i) begin
         if (!wr_en) begin
            state_d = ST_IDLE;
         end else if (wr_load == '0) begin
            state_d = ST_EXPIRED;
         end else begin
            state_d = ST_COUNT;
         end
      end else if (expire) begin
`ifdef TIMER_AUTORELOAD_EN
         state_d = ST_COUNT;
`else
         state_d = ST_EXPIRED;
`endif
      end
   end

   // Datapath next values: load/pause/clear on writes, then prescale and count down.
   always_comb begin
      count_d     = count_q;
      prescaler_d = prescaler_q;
      done_d      = done_q;
      irq_d       = 1'b0;
`ifdef TIMER_AUTORELOAD_EN
      period_d    = period_q;
`endif
      if (bus.we_i) begin
         if (wr_en) begin
            if (wr_load != '0) begin
               count_d     = wr_load;
               prescaler_d = '0;
               done_d      = 1'b0;
`ifdef TIMER_AUTORELOAD_EN
               period_d    = wr_load;
`endif
            end else begin
               // A zero load expires at once and still raises the interrupt.
               count_d     = '0;
               prescaler_d = '0;
               done_d      = 1'b1;
               irq_d       = 1'b1;
            end
         end else if (wr_clr) begin
            // A pause holds count and prescaler; only CLR_DONE touches done.
            done_d = 1'b0;
         end
      end else if (state_q == ST_COUNT) begin
         if (tick) begin
            prescaler_d = '0;
            if (expire) begin
               done_d = 1'b1;
               irq_d  = 1'b1;
`ifdef TIMER_AUTORELOAD_EN
               count_d = period_q;
`else
               count_d = '0;
`endif
            end else begin
               count_d = count_q - CNT_W'(1);
            end
         end else begin
            prescaler_d = prescaler_q + PS_W'(1);
         end
      end
   end

   // Outputs come straight from registers, so do_o reads 0 while reset is held.
   always_comb begin
      running     = (state_q == ST_COUNT);
      bus.do_o    = {done_q, running, count_q};
      bus.irq_o   = irq_q;
      state_dbg_o = state_q;
   end

endmodule
